// File: rtl/me_search_ctrl.sv
// Full-search motion-estimation controller: loads the reference block, streams
// all 256 displacements to a SAD datapath and keeps the first-scanned minimum.
module me_search_ctrl #(
  parameter int REF_ROWS = 8,
  parameter int SAD_W    = 13,
  parameter int MAX_OUT  = 4
) (
  input  logic             CLK,
  input  logic             resetn,
  input  logic             start,
  output logic             ref_we,
  output logic [2:0]       ref_addr,
  output logic             cand_valid,
  input  logic             cand_ready,
  output logic [3:0]       cand_x,
  output logic [3:0]       cand_y,
  input  logic             sad_valid,
  input  logic [SAD_W-1:0] sad,
  output logic [3:0]       vector_x,
  output logic [3:0]       vector_y,
  output logic [SAD_W-1:0] min_sad,
  output logic             done,
  output logic             busy,
  output logic             err
);

  localparam int                IFW       = $clog2(MAX_OUT + 1);
  localparam logic [8:0]        N_CAND    = 9'd256;
  localparam logic [2:0]        LAST_ROW  = 3'(REF_ROWS - 1);
  localparam logic signed [3:0] COORD_MIN = 4'sb1000;
  localparam logic signed [3:0] COORD_MAX = 4'sb0111;

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, DONE} state_t;

  state_t                   state_q, state_d;
  logic                     ref_we_q, ref_we_d;
  logic [2:0]               ref_addr_q, ref_addr_d;
  logic                     cand_valid_q, cand_valid_d;
  logic signed [3:0]        cand_x_q, cand_x_d;
  logic signed [3:0]        cand_y_q, cand_y_d;
  logic [8:0]               issued_q, issued_d;
  logic [8:0]               res_cnt_q, res_cnt_d;
  logic signed [3:0]        res_x_q, res_x_d;
  logic signed [3:0]        res_y_q, res_y_d;
  logic [IFW-1:0]           inflight_q, inflight_d;
  logic [SAD_W-1:0]         best_sad_q, best_sad_d;
  logic signed [3:0]        best_x_q, best_x_d;
  logic signed [3:0]        best_y_q, best_y_d;
  logic [3:0]               vector_x_q, vector_x_d;
  logic [3:0]               vector_y_q, vector_y_d;
  logic [SAD_W-1:0]         min_sad_q, min_sad_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;
  logic                     err_q, err_d;
  logic                     issue;
  logic                     sad_ok;

  // Raster step: x runs -8..+7 and wraps, carrying into y.
  function automatic logic [7:0] scan_next(input logic signed [3:0] x,
                                           input logic signed [3:0] y);
    logic signed [3:0] nx;
    logic signed [3:0] ny;
    nx = x + 4'sd1;
    ny = (x == COORD_MAX) ? y + 4'sd1 : y;
    return {ny, nx};
  endfunction

  always_comb begin
    state_d      = state_q;
    ref_we_d     = ref_we_q;
    ref_addr_d   = ref_addr_q;
    cand_x_d     = cand_x_q;
    cand_y_d     = cand_y_q;
    issued_d     = issued_q;
    res_cnt_d    = res_cnt_q;
    res_x_d      = res_x_q;
    res_y_d      = res_y_q;
    inflight_d   = inflight_q;
    best_sad_d   = best_sad_q;
    best_x_d     = best_x_q;
    best_y_d     = best_y_q;
    vector_x_d   = vector_x_q;
    vector_y_d   = vector_y_q;
    min_sad_d    = min_sad_q;
    done_d       = 1'b0;
    err_d        = err_q;

    issue  = (state_q == ISSUE) && cand_valid_q && cand_ready;
    sad_ok = sad_valid && (inflight_q != '0) &&
             ((state_q == ISSUE) || (state_q == DRAIN));

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          err_d      = 1'b0;
          ref_we_d   = 1'b1;
          ref_addr_d = 3'd0;
          cand_x_d   = COORD_MIN;
          cand_y_d   = COORD_MIN;
          res_x_d    = COORD_MIN;
          res_y_d    = COORD_MIN;
          issued_d   = 9'd0;
          res_cnt_d  = 9'd0;
          inflight_d = '0;
          best_sad_d = '1;
          best_x_d   = COORD_MIN;
          best_y_d   = COORD_MIN;
        end
      end
      LOAD: begin
        if (ref_addr_q == LAST_ROW) begin
          state_d  = ISSUE;
          ref_we_d = 1'b0;
        end else begin
          ref_addr_d = ref_addr_q + 3'd1;
        end
      end
      ISSUE: begin
        if (issue) begin
          issued_d               = issued_q + 9'd1;
          {cand_y_d, cand_x_d}   = scan_next(cand_x_q, cand_y_q);
          if (issued_q == N_CAND - 9'd1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((inflight_q == '0) && (res_cnt_q == N_CAND)) begin
          state_d    = DONE;
          done_d     = 1'b1;
          vector_x_d = best_x_q;
          vector_y_d = best_y_q;
          min_sad_d  = best_sad_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (issue && !sad_ok)      inflight_d = inflight_q + IFW'(1);
    else if (!issue && sad_ok) inflight_d = inflight_q - IFW'(1);

    // Results come back in issue order, so a second raster walker tags them.
    if (sad_ok) begin
      res_cnt_d          = res_cnt_q + 9'd1;
      {res_y_d, res_x_d} = scan_next(res_x_q, res_y_q);
      if (sad < best_sad_q) begin
        best_sad_d = sad;
        best_x_d   = res_x_q;
        best_y_d   = res_y_q;
      end
    end

    if (sad_valid && !sad_ok) err_d = 1'b1;

    cand_valid_d = (state_d == ISSUE) && (inflight_d < IFW'(MAX_OUT)) &&
                   (issued_d != N_CAND);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      ref_we_q     <= 1'b0;
      ref_addr_q   <= '0;
      cand_valid_q <= 1'b0;
      cand_x_q     <= '0;
      cand_y_q     <= '0;
      issued_q     <= '0;
      res_cnt_q    <= '0;
      res_x_q      <= '0;
      res_y_q      <= '0;
      inflight_q   <= '0;
      best_sad_q   <= '0;
      best_x_q     <= '0;
      best_y_q     <= '0;
      vector_x_q   <= '0;
      vector_y_q   <= '0;
      min_sad_q    <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ref_we_q     <= ref_we_d;
      ref_addr_q   <= ref_addr_d;
      cand_valid_q <= cand_valid_d;
      cand_x_q     <= cand_x_d;
      cand_y_q     <= cand_y_d;
      issued_q     <= issued_d;
      res_cnt_q    <= res_cnt_d;
      res_x_q      <= res_x_d;
      res_y_q      <= res_y_d;
      inflight_q   <= inflight_d;
      best_sad_q   <= best_sad_d;
      best_x_q     <= best_x_d;
      best_y_q     <= best_y_d;
      vector_x_q   <= vector_x_d;
      vector_y_q   <= vector_y_d;
      min_sad_q    <= min_sad_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign ref_we     = ref_we_q;
  assign ref_addr   = ref_addr_q;
  assign cand_valid = cand_valid_q;
  assign cand_x     = cand_x_q;
  assign cand_y     = cand_y_q;
  assign vector_x   = vector_x_q;
  assign vector_y   = vector_y_q;
  assign min_sad    = min_sad_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_me_search_ctrl.sv
// Directed/randomised bench for me_search_ctrl with a fixed-latency SAD
// datapath stand-in and a raster-scan reference for the expected best vector.
module tb_me_search_ctrl;

  localparam int REF_ROWS = 8;
  localparam int SAD_W    = 13;
  localparam int MAX_OUT  = 4;

  logic             CLK = 1'b0;
  logic             resetn;
  logic             start;
  logic             cand_ready;
  logic             sad_valid;
  logic [SAD_W-1:0] sad;
  logic             ref_we;
  logic [2:0]       ref_addr;
  logic             cand_valid;
  logic [3:0]       cand_x, cand_y;
  logic [3:0]       vector_x, vector_y;
  logic [SAD_W-1:0] min_sad;
  logic             done, busy, err;

  me_search_ctrl #(.REF_ROWS(REF_ROWS), .SAD_W(SAD_W), .MAX_OUT(MAX_OUT)) dut (
    .CLK(CLK), .resetn(resetn), .start(start),
    .ref_we(ref_we), .ref_addr(ref_addr),
    .cand_valid(cand_valid), .cand_ready(cand_ready),
    .cand_x(cand_x), .cand_y(cand_y),
    .sad_valid(sad_valid), .sad(sad),
    .vector_x(vector_x), .vector_y(vector_y), .min_sad(min_sad),
    .done(done), .busy(busy), .err(err)
  );

  always #5 CLK = ~CLK;

  int   tab [256];          // SAD per displacement, index (y+8)*16 + (x+8)
  int   q_val [$];
  int   q_due [$];
  int   cyc, lat;
  bit   rdy_rand;
  int   n_iss, n_ret, done_cnt, ref_cnt, ref_bad, order_bad, stab_bad, max_if;
  bit   hold_pend;
  logic [3:0] hold_x, hold_y;
  int   n_pass, n_total, n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    q_val.delete();
    q_due.delete();
    n_iss = 0; n_ret = 0; done_cnt = 0; ref_cnt = 0; ref_bad = 0;
    order_bad = 0; stab_bad = 0; max_if = 0; hold_pend = 1'b0;
  endtask

  // One clock: observe outputs at the falling edge, then drive the inputs
  // that the next rising edge will see (ready, returning SAD).
  task automatic step();
    int sx, sy;
    @(negedge CLK);
    cyc++;
    if (done) done_cnt++;
    if (ref_we) begin
      if (ref_addr !== 3'(ref_cnt)) ref_bad++;
      ref_cnt++;
    end
    if (hold_pend && cand_valid && ((cand_x !== hold_x) || (cand_y !== hold_y))) stab_bad++;
    cand_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (cand_valid && cand_ready) begin
      sx = $signed(cand_x);
      sy = $signed(cand_y);
      if ((sx != (n_iss % 16) - 8) || (sy != (n_iss / 16) - 8)) order_bad++;
      q_val.push_back(tab[(sy + 8) * 16 + (sx + 8)]);
      q_due.push_back(cyc + lat);
      n_iss++;
      hold_pend = 1'b0;
    end else begin
      hold_pend = cand_valid;
      hold_x    = cand_x;
      hold_y    = cand_y;
    end
    if ((q_due.size() > 0) && (q_due[0] <= cyc)) begin
      sad_valid = 1'b1;
      sad       = SAD_W'(q_val.pop_front());
      void'(q_due.pop_front());
      n_ret++;
    end else begin
      sad_valid = 1'b0;
      sad       = '0;
    end
    if (n_iss - n_ret > max_if) max_if = n_iss - n_ret;
  endtask

  // Reference: walk displacements y outer, x inner, keep strict minimum.
  task automatic model(output int bx, output int by, output int bs);
    bit first;
    first = 1'b1;
    bx = 0; by = 0; bs = 0;
    for (int y = -8; y <= 7; y++) begin
      for (int x = -8; x <= 7; x++) begin
        int v;
        v = tab[(y + 8) * 16 + (x + 8)];
        if (first || (v < bs)) begin
          bs = v; bx = x; by = y; first = 1'b0;
        end
      end
    end
  endtask

  task automatic run_search(input string name, input int l, input bit rr, input bit hold);
    int bx, by, bs;
    clear_mon();
    lat      = l;
    rdy_rand = rr;
    start    = 1'b1;
    step();
    if (!hold) begin
      start = 1'b0;
      check({name, "_busy_start"}, busy, 1);
      check({name, "_err_clr"}, err, 0);
    end
    for (int i = 0; (i < 20000) && (done_cnt == 0); i++) step();
    model(bx, by, bs);
    check({name, "_done_seen"}, done_cnt, 1);
    check({name, "_vec_x"}, vector_x, bx & 15);
    check({name, "_vec_y"}, vector_y, by & 15);
    check({name, "_min_sad"}, min_sad, bs);
    check({name, "_issues"}, n_iss, 256);
    check({name, "_results"}, n_ret, 256);
    check({name, "_ref_rows"}, ref_cnt, REF_ROWS);
    check({name, "_ref_addr"}, ref_bad, 0);
    check({name, "_order"}, order_bad, 0);
    check({name, "_stable"}, stab_bad, 0);
    check({name, "_inflight"}, (max_if <= MAX_OUT), 1);
    check({name, "_err"}, err, 0);
    if (!hold) begin
      repeat (3) step();
      check({name, "_one_done"}, done_cnt, 1);
      check({name, "_idle"}, busy, 0);
      check({name, "_hold_vec"}, {vector_y, vector_x}, {4'(by & 15), 4'(bx & 15)});
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0; n_fail = 0; cyc = 0; lat = 3; rdy_rand = 1'b0;
    resetn = 1'b0; start = 1'b0; cand_ready = 1'b0; sad_valid = 1'b0; sad = '0;
    clear_mon();
    step(); step();
    check("rst_ctrl", {ref_we, ref_addr, cand_valid, done, busy, err}, 0);
    resetn = 1'b1;
    step();
    check("idle_outs", {vector_x, vector_y, min_sad, cand_x, cand_y, busy, err}, 0);

    // Single minimum at (+2,-3), latency 3, always ready.
    for (int i = 0; i < 256; i++) tab[i] = 100;
    tab[(-3 + 8) * 16 + (2 + 8)] = 5;
    run_search("basic", 3, 1'b0, 1'b0);
    check("basic_vx_bits", vector_x, 4'b0010);
    check("basic_vy_bits", vector_y, 4'b1101);
    check("basic_sad5", min_sad, 5);

    // Stray SAD while idle: flags err, nothing else moves.
    sad_valid = 1'b1;
    sad       = 13'd3;
    step();
    check("idle_sad_err", err, 1);
    check("idle_sad_busy", busy, 0);
    check("idle_sad_vec", {vector_y, vector_x, min_sad}, {4'b1101, 4'b0010, 13'd5});

    // All equal: first-scanned candidate wins.
    for (int i = 0; i < 256; i++) tab[i] = 7;
    run_search("tie", 3, 1'b0, 1'b0);
    check("tie_vec_bits", {vector_y, vector_x}, 8'b1000_1000);

    // Random SADs under random backpressure and long latency.
    for (int i = 0; i < 256; i++) tab[i] = int'($urandom_range(200, 8191));
    tab[int'($urandom_range(0, 255))] = 17;
    tab[int'($urandom_range(0, 255))] = 17;
    run_search("bp", 10, 1'b1, 1'b0);

    // Reset after 100 issues abandons the search.
    for (int i = 0; i < 256; i++) tab[i] = int'($urandom_range(0, 8191));
    clear_mon();
    lat = 3; rdy_rand = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; (i < 2000) && (n_iss < 100); i++) step();
    check("pre_rst_issues", (n_iss >= 100), 1);
    resetn = 1'b0;
    #1;
    check("rst_mid_a", {ref_we, ref_addr, cand_valid, cand_x, cand_y, done, busy, err}, 0);
    check("rst_mid_b", {vector_x, vector_y, min_sad}, 0);
    step();
    resetn = 1'b1;
    repeat (6) step();
    check("rst_no_done", done_cnt, 0);
    check("rst_late_err", err, 1);
    check("rst_idle", busy, 0);
    run_search("after_rst", 3, 1'b0, 1'b0);

    // start held high: two back-to-back searches.
    for (int i = 0; i < 256; i++) tab[i] = int'($urandom_range(0, 8191));
    run_search("b2b_1", 3, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) tab[i] = int'($urandom_range(0, 8191));
    run_search("b2b_2", 4, 1'b1, 1'b1);
    start = 1'b0;
    repeat (4) step();
    check("b2b_one_done", done_cnt, 1);
    check("b2b_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/me_search_ctrl.md
ME_SEARCH_CTRL -- requirements
Module: me_search_ctrl

Interface
REQ-001 The block SHALL have parameters: REF_ROWS, 8, reference-block rows loaded per search; SAD_W, 13, SAD width; MAX_OUT, 4, maximum candidates in flight in the SAD datapath.
REQ-002 The block SHALL use one clock and an asynchronous active-low reset: CLK  in  1  rising-edge clock; resetn  in  1  async active-low reset.
REQ-003 start  in  1  request a new block search; sampled only in IDLE.
REQ-004 ref_we  out  1  write the current 88-bit WriteData row into the PE reference array.
REQ-005 ref_addr  out  3  reference row index.
REQ-006 cand_valid  out  1  candidate displacement offered to the datapath.
REQ-007 cand_ready  in  1  datapath accepts the candidate.
REQ-008 cand_x, cand_y  out  4 each  candidate displacement, two's complement, -8..+7.
REQ-009 sad_valid  in  1  SAD result present.
REQ-010 sad  in  SAD_W  SAD result.
REQ-011 vector_x, vector_y  out  4 each  best displacement, two's complement.
REQ-012 min_sad  out  SAD_W  SAD of the best candidate.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 err  out  1  sticky protocol error flag.

Function
REQ-016 The block SHALL implement the states IDLE, LOAD, ISSUE, DRAIN and DONE.
REQ-017 IDLE: start=1 SHALL go to LOAD, clear err, set the internal best SAD to all-ones and clear the candidate and result counters.
REQ-018 LOAD SHALL assert ref_we for exactly REF_ROWS consecutive cycles with ref_addr 0..REF_ROWS-1, then go to ISSUE.
REQ-019 ISSUE SHALL assert cand_valid whenever in-flight < MAX_OUT and candidates remain; cand_x/cand_y SHALL stay stable while cand_valid=1 and cand_ready=0.
REQ-020 Scan order SHALL be y outer, x inner, each stepping -8 to +7: 256 candidates, first (-8,-8), last (+7,+7).
REQ-021 A candidate SHALL be issued on the cycle cand_valid=1 and cand_ready=1; the 256th issue SHALL go to DRAIN.
REQ-022 The in-flight counter SHALL increment on issue and decrement on sad_valid; on a simultaneous issue and return it SHALL be unchanged.
REQ-023 SAD results SHALL be associated with candidates in issue order via a separate result counter using the same scan order.
REQ-024 A result SHALL replace the best only if sad < best (strict), so the first-scanned minimum wins ties.
REQ-025 DRAIN SHALL go to DONE in the cycle after the in-flight count reaches 0 with 256 results received.
REQ-026 DONE SHALL last one cycle, assert done=1, load vector_x, vector_y and min_sad from the best, then go to IDLE.
REQ-027 vector_x, vector_y and min_sad SHALL hold their values until the next DONE.
REQ-028 sad_valid with in-flight = 0, or in IDLE, LOAD or DONE, SHALL be ignored and SHALL set err; err SHALL clear only on an accepted start or on reset.
REQ-029 start outside IDLE SHALL be ignored and SHALL NOT set err.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 resetn=0 SHALL asynchronously force IDLE and set every output and counter to 0, including vector_x, vector_y, min_sad, done, busy, err, cand_valid and ref_we.
REQ-032 Reset mid-search SHALL abandon the search with no done pulse; results arriving after reset release SHALL set err.

Verification
REQ-033 Reset, then start, cand_ready tied 1, datapath latency 3, all SADs 100 except (+2,-3)=5 -> vector_x=0010, vector_y=1101, min_sad=5, done pulse once, ref_we for 8 cycles at addr 0..7.
REQ-034 All SADs equal to 7 -> vector=(-8,-8), i.e. 1000/1000, and min_sad=7 (tie rule).
REQ-035 cand_ready random 50%, latency 10 -> in-flight never exceeds 4, cand_x/cand_y stable under backpressure, exactly 256 issues and 256 results.
REQ-036 sad_valid pulsed in IDLE -> err=1 and no other state change; the next start clears err.
REQ-037 resetn asserted after 100 issues -> all outputs 0 immediately, no done; a new start completes normally.
REQ-038 start held high through a whole search -> back-to-back searches, each with exactly one done pulse.
